// File: rtl/agtb2_checker_if.sv
// Operand, response and status bundle between the agtb2 checker and its controller/DUT side.
// The master side drives start and the comparator response; the slave is the checker.
interface agtb2_checker_if;
  logic       start;
  logic       dut_agtb;
  logic [1:0] a_out;
  logic [1:0] b_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_cnt;
  logic [3:0] first_fail_vec;

  modport master (
    output start, dut_agtb,
    input  a_out, b_out, busy, done, pass, err_cnt, first_fail_vec
  );

  modport slave (
    input  start, dut_agtb,
    output a_out, b_out, busy, done, pass, err_cnt, first_fail_vec
  );
endinterface

// File: rtl/agtb2_checker.sv
// Exhaustive 16-vector exerciser and response checker for a 2-bit a>b comparator.
// Latency: done 16*(DWELL+1) cycles after start; no backpressure, start ignored while busy.
module agtb2_checker #(
  parameter int unsigned DWELL = 4
) (
  input  logic           clk,
  input  logic           reset,
  agtb2_checker_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

  logic [1:0] state;
  logic [3:0] vec;
  logic [7:0] cnt;
  logic [4:0] err_cnt;
  logic [3:0] first_fail_vec;
  logic       fail_seen;
  logic       exp_agtb;

  // Operands come straight from the vector register; vec stays at 15 in DONE,
  // so a_out/b_out hold 2'b11 there without extra logic.
  assign bus.a_out = vec[3:2];
  assign bus.b_out = vec[1:0];
  assign exp_agtb  = (vec[3:2] > vec[1:0]);

  assign bus.busy           = (state == SETTLE) || (state == CHECK);
  assign bus.done           = (state == DONE);
  assign bus.pass           = (state == DONE) && (err_cnt == 5'd0);
  assign bus.err_cnt        = err_cnt;
  assign bus.first_fail_vec = first_fail_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      vec            <= 4'd0;
      cnt            <= 8'd0;
      err_cnt        <= 5'd0;
      first_fail_vec <= 4'd0;
      fail_seen      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state          <= SETTLE;
            vec            <= 4'd0;
            cnt            <= 8'd0;
            err_cnt        <= 5'd0;
            first_fail_vec <= 4'd0;
            fail_seen      <= 1'b0;
          end
        end
        SETTLE: begin
          cnt <= cnt + 8'd1;
          if (cnt == DWELL_M1) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (bus.dut_agtb != exp_agtb) begin
            err_cnt <= err_cnt + 5'd1;
            if (!fail_seen) begin
              first_fail_vec <= vec;
              fail_seen      <= 1'b1;
            end
          end
          if (vec == 4'hf) begin
            state <= DONE;
          end else begin
            vec   <= vec + 4'd1;
            cnt   <= 8'd0;
            state <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_agtb2_checker.sv
// Bench for agtb2_checker: cycle-indexed sweep model plus directed sweeps with
// hand-computed error counts for several faulty comparator behaviours.
module tb_agtb2_checker;
  localparam int DW = 4;
  localparam int SWEEP = 16 * (DW + 1);

  logic clk;
  logic reset;
  int   mode;  // 0 correct a>b, 1 stuck-at-0, 2 a<=b, 3 a>=b

  int checks;
  int failures;

  agtb2_checker_if bus ();

  agtb2_checker #(.DWELL(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic resp(input int m, input int v);
    int a, b;
    a = (v >> 2) & 3;
    b = v & 3;
    case (m)
      0:       return logic'(a > b);
      1:       return 1'b0;
      2:       return logic'(a <= b);
      default: return logic'(a >= b);
    endcase
  endfunction

  function automatic logic golden(input int v);
    return logic'(((v >> 2) & 3) > (v & 3));
  endfunction

  always_comb bus.dut_agtb = resp(mode, {28'd0, bus.a_out, bus.b_out});

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Model state: k counts clock edges since the accepted start edge.
  bit m_valid = 0;
  bit m_busy, m_done, m_seen;
  int m_k, m_err, m_ffv;

  always @(posedge clk) begin
    int v, ea, eb;
    if (reset) begin
      m_valid = 1; m_busy = 0; m_done = 0; m_seen = 0;
      m_k = 0; m_err = 0; m_ffv = 0;
    end else if (m_valid) begin
      if (!m_busy) begin
        if (bus.start) begin
          m_busy = 1; m_done = 0; m_seen = 0;
          m_k = 0; m_err = 0; m_ffv = 0;
        end
      end else begin
        if (m_k % (DW + 1) == DW) begin
          v = m_k / (DW + 1);
          if (resp(mode, v) != golden(v)) begin
            m_err++;
            if (!m_seen) begin
              m_ffv = v;
              m_seen = 1;
            end
          end
        end
        m_k++;
        if (m_k == SWEEP) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
    #1;
    if (m_valid) begin
      if (m_busy) begin
        v = m_k / (DW + 1); ea = (v >> 2) & 3; eb = v & 3;
      end else if (m_done) begin
        ea = 3; eb = 3;
      end else begin
        ea = 0; eb = 0;
      end
      chk("busy",   8'(bus.busy), 8'(m_busy));
      chk("done",   8'(bus.done), 8'(m_done));
      chk("pass",   8'(bus.pass), 8'(m_done && m_err == 0));
      chk("a_out",  8'(bus.a_out), 8'(ea));
      chk("b_out",  8'(bus.b_out), 8'(eb));
      chk("err_cnt", 8'(bus.err_cnt), 8'(m_err));
      chk("first_fail_vec", 8'(bus.first_fail_vec), 8'(m_ffv));
      chk("busy_done_excl", 8'(bus.busy && bus.done), 8'd0);
    end
  end

  // Pulse start for one edge, then count edges until done; n returns that count.
  task automatic sweep(input string tag, output int n);
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < SWEEP + 40) begin
      @(posedge clk); #2;
      n++;
      bus.start = (n == 20 || n == 40 || n == 60) && (tag == "busy_start");
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, 8'(n), 8'd80);
  endtask

  task automatic expect_result(input string tag, input int e, input int f, input int p);
    chk({tag, "_err_cnt"}, 8'(bus.err_cnt), 8'(e));
    chk({tag, "_ffv"},     8'(bus.first_fail_vec), 8'(f));
    chk({tag, "_pass"},    8'(bus.pass), 8'(p));
    chk({tag, "_done"},    8'(bus.done), 8'd1);
  endtask

  initial begin
    int n;
    checks = 0; failures = 0;
    mode = 0;
    reset = 1'b1;
    bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 8'(bus.busy), 8'd0);
    chk("rst_done", 8'(bus.done), 8'd0);
    chk("rst_a",    8'(bus.a_out), 8'd0);
    chk("rst_err",  8'(bus.err_cnt), 8'd0);
    bus.start = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("idle_busy", 8'(bus.busy), 8'd0);

    mode = 0; sweep("correct", n);  expect_result("correct", 0, 0, 1);
    mode = 1; sweep("stuck0", n);   expect_result("stuck0", 6, 4'b0100, 0);
    mode = 2; sweep("inverted", n); expect_result("inverted", 16, 4'b0000, 0);
    mode = 3; sweep("ge", n);       expect_result("ge", 4, 4'b0000, 0);
    mode = 0; sweep("restart", n);  expect_result("restart", 0, 0, 1);

    sweep("busy_start", n);
    expect_result("busy_start", 0, 0, 1);

    // Abort mid-sweep while vector 7 (a=1,b=3) is on the bus.
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    repeat (37) @(posedge clk);
    #2;
    chk("mid_a", 8'(bus.a_out), 8'd1);
    chk("mid_b", 8'(bus.b_out), 8'd3);
    chk("mid_busy", 8'(bus.busy), 8'd1);
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    chk("abort_busy", 8'(bus.busy), 8'd0);
    chk("abort_a",    8'(bus.a_out), 8'd0);
    chk("abort_b",    8'(bus.b_out), 8'd0);
    chk("abort_done", 8'(bus.done), 8'd0);
    mode = 1; sweep("after_abort", n); expect_result("after_abort", 6, 4'b0100, 0);

    repeat (3) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
